// File: rtl/addsub_field_if.sv
// addsub_field_if: request/result bundle for the addsub_field unit
// Parameters:
//   BYTES, BYTE_W - word geometry, must match the attached addsub_field
// Signals:
//   start, op, field, in1, in2                          - request (master -> slave)
//   stop, busy, out, overflow, cmp_lt/eq/gt, err        - result  (slave -> master)
interface addsub_field_if #(
    parameter int BYTES  = 5,
    parameter int BYTE_W = 6
);
    localparam int W  = BYTES * BYTE_W + 1;
    localparam int FW = $clog2(BYTES + 1);

    logic            start;
    logic [1:0]      op;
    logic [2*FW-1:0] field;
    logic [W-1:0]    in1;
    logic [W-1:0]    in2;
    logic            stop;
    logic            busy;
    logic [W-1:0]    out;
    logic            overflow;
    logic            cmp_lt;
    logic            cmp_eq;
    logic            cmp_gt;
    logic            err;

    modport master (
        output start, op, field, in1, in2,
        input  stop, busy, out, overflow, cmp_lt, cmp_eq, cmp_gt, err
    );

    modport slave (
        input  start, op, field, in1, in2,
        output stop, busy, out, overflow, cmp_lt, cmp_eq, cmp_gt, err
    );
endinterface

// File: rtl/addsub_field.sv
// addsub_field: byte-serial sign-magnitude ADD/SUB/CMP with MIX (L:R) field extraction
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - addsub_field_if.slave; start/op/field/in1/in2 in,
//           stop/busy/out/overflow/cmp_lt/cmp_eq/cmp_gt/err out
module addsub_field #(
    parameter int BYTES  = 5,
    parameter int BYTE_W = 6
) (
    input logic           clk,
    input logic           rst_n,
    addsub_field_if.slave bus
);
    localparam int M  = BYTES * BYTE_W;
    localparam int W  = M + 1;
    localparam int FW = $clog2(BYTES + 1);
    localparam logic [FW-1:0] MAX_IDX = FW'(BYTES);
    localparam logic [FW-1:0] LAST    = FW'(BYTES - 1);
    localparam logic [1:0] IDLE = 2'd0, PREP = 2'd1, RUN = 2'd2, DONE = 2'd3;
    localparam logic [1:0] OP_SUB = 2'b01, OP_CMP = 2'b10, OP_BAD = 2'b11;

    logic [1:0]      state_q, state_d, op_q, op_d;
    logic [2*FW-1:0] field_q, field_d;
    logic [W-1:0]    in1_q, in1_d, in2_q, in2_d, out_q, out_d;
    logic [M-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [FW-1:0]   cnt_q, cnt_d;
    logic            eff_sub_q, eff_sub_d, sign_q, sign_d, cy_q, cy_d;
    logic            overflow_q, overflow_d, lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, err_q, err_d;

    logic [FW-1:0]   fl, fr, fl_eff;
    logic [M-1:0]    m1, v_mag;
    logic            s1, v_sign, sv, illegal, swap, neg1, negv, mag_lt, mag_eq, c_lt, c_eq;
    logic [BYTE_W:0] sum;

    assign fl      = field_q[2*FW-1:FW];
    assign fr      = field_q[FW-1:0];
    assign fl_eff  = (fl == '0) ? FW'(1) : fl;
    assign m1      = in1_q[M-1:0];
    assign s1      = in1_q[M];
    assign v_sign  = (fl == '0) & in2_q[M];
    assign illegal = (fr < fl) | (fr > MAX_IDX) | (op_q == OP_BAD);

    // Result byte i takes source byte R-i (byte 1 = MSB) while that byte is inside L'..R
    always_comb begin
        v_mag = '0;
        for (int i = 0; i < BYTES; i++)
            if (int'(fr) - i >= int'(fl_eff) && int'(fr) - i <= BYTES)
                v_mag[i*BYTE_W +: BYTE_W] = in2_q[(BYTES - int'(fr) + i)*BYTE_W +: BYTE_W];
    end

    assign sv     = v_sign ^ (op_q == OP_SUB);
    assign mag_lt = m1 < v_mag;
    assign mag_eq = m1 == v_mag;
    assign swap   = (s1 ^ sv) & mag_lt;
    // A zero magnitude counts as non-negative so +0 and -0 compare equal
    assign neg1   = s1 & (m1 != '0);
    assign negv   = v_sign & (v_mag != '0);
    assign c_eq   = mag_eq & (neg1 == negv);
    assign c_lt   = (neg1 != negv) ? neg1 : (neg1 ? ~(mag_lt | mag_eq) : mag_lt);
    // Subtraction is a + ~b + 1, the +1 being the carry preloaded in PREP
    assign sum    = {1'b0, a_q[BYTE_W-1:0]} + {1'b0, b_q[BYTE_W-1:0] ^ {BYTE_W{eff_sub_q}}}
                  + {{BYTE_W{1'b0}}, cy_q};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        field_d    = field_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        out_d      = out_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        eff_sub_d  = eff_sub_q;
        sign_d     = sign_q;
        cy_d       = cy_q;
        overflow_d = overflow_q;
        lt_d       = lt_q;
        eq_d       = eq_q;
        gt_d       = gt_q;
        err_d      = err_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = bus.start ? PREP : IDLE;
                if (bus.start) begin
                    op_d    = bus.op;
                    field_d = bus.field;
                    in1_d   = bus.in1;
                    in2_d   = bus.in2;
                end
            end
            PREP: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = DONE;
                end else if (op_q == OP_CMP) begin
                    err_d      = 1'b0;
                    overflow_d = 1'b0;
                    lt_d       = c_lt;
                    eq_d       = c_eq;
                    gt_d       = ~c_lt & ~c_eq;
                    state_d    = DONE;
                end else begin
                    eff_sub_d = s1 ^ sv;
                    a_d       = swap ? v_mag : m1;
                    b_d       = swap ? m1 : v_mag;
                    sign_d    = swap ? sv : s1;
                    cy_d      = s1 ^ sv;
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end
            default: begin
                acc_d = {sum[BYTE_W-1:0], acc_q[M-1:BYTE_W]};
                a_d   = a_q >> BYTE_W;
                b_d   = b_q >> BYTE_W;
                cy_d  = sum[BYTE_W];
                cnt_d = cnt_q + FW'(1);
                if (cnt_q == LAST) begin
                    out_d      = {sign_q, acc_d};
                    overflow_d = ~eff_sub_q & sum[BYTE_W];
                    lt_d       = 1'b0;
                    eq_d       = 1'b0;
                    gt_d       = 1'b0;
                    err_d      = 1'b0;
                    state_d    = DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            field_q    <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            out_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            eff_sub_q  <= 1'b0;
            sign_q     <= 1'b0;
            cy_q       <= 1'b0;
            overflow_q <= 1'b0;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
            gt_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            field_q    <= field_d;
            in1_q      <= in1_d;
            in2_q      <= in2_d;
            out_q      <= out_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            eff_sub_q  <= eff_sub_d;
            sign_q     <= sign_d;
            cy_q       <= cy_d;
            overflow_q <= overflow_d;
            lt_q       <= lt_d;
            eq_q       <= eq_d;
            gt_q       <= gt_d;
            err_q      <= err_d;
        end
    end

    assign bus.stop     = state_q == DONE;
    assign bus.busy     = state_q != IDLE;
    assign bus.out      = out_q;
    assign bus.overflow = overflow_q;
    assign bus.cmp_lt   = lt_q;
    assign bus.cmp_eq   = eq_q;
    assign bus.cmp_gt   = gt_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_addsub_field.sv
// tb_addsub_field: directed self-checking bench for addsub_field (BYTES=5, BYTE_W=6)
module tb_addsub_field;
    localparam int BYTES = 5, BYTE_W = 6, M = 30, W = 31, FW = 3;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, CMP = 2'b10, BAD = 2'b11;
    localparam longint BYTES12345 = (1 << 24) | (2 << 18) | (3 << 12) | (4 << 6) | 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0, n_fail = 0;
    int stop_cyc;
    bit busy_ok, busy_after, stop_after, seen;
    logic [W-1:0] got_out, held_out;
    logic got_ov, got_err;
    logic [2:0] got_cmp;

    addsub_field_if #(.BYTES(BYTES), .BYTE_W(BYTE_W)) bus ();
    addsub_field #(.BYTES(BYTES), .BYTE_W(BYTE_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] w(input bit s, input longint m);
        return {s, m[M-1:0]};
    endfunction

    function automatic logic [2*FW-1:0] fs(input int l, input int r);
        return {l[FW-1:0], r[FW-1:0]};
    endfunction

    // Issue one request; poke>0 raises a stray start (with junk operands) in that busy cycle
    task automatic do_op(input logic [1:0] o, input logic [2*FW-1:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.field = f; bus.in1 = a; bus.in2 = b;
        stop_cyc = -1; busy_ok = 1'b1;
        got_out = '1; got_ov = 1'b1; got_cmp = '1; got_err = 1'b1;
        for (int c = 1; c <= 20 && stop_cyc < 0; c++) begin
            @(negedge clk);
            bus.start = (c == poke);
            if (c == poke) begin
                bus.op = ADD; bus.field = fs(0, 5); bus.in1 = '1; bus.in2 = '1;
            end
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.stop) begin
                stop_cyc = c;
                got_out = bus.out; got_ov = bus.overflow; got_err = bus.err;
                got_cmp = {bus.cmp_lt, bus.cmp_eq, bus.cmp_gt};
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        busy_after = bus.busy; stop_after = bus.stop; held_out = bus.out;
    endtask

    task automatic expect_op(input string tag, input int cyc, input logic [W-1:0] o,
                             input logic ov, input logic [2:0] cmp, input logic e);
        check({tag, ".stop_cycle"}, stop_cyc, cyc);
        check({tag, ".busy_stop"}, {busy_ok, busy_after, stop_after}, 3'b100);
        check({tag, ".out"}, got_out, o);
        check({tag, ".overflow"}, got_ov, ov);
        check({tag, ".cmp"}, got_cmp, cmp);
        check({tag, ".err"}, got_err, e);
        check({tag, ".held"}, held_out, o);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = ADD; bus.field = '0; bus.in1 = '0; bus.in2 = '0;
        repeat (2) @(negedge clk);
        check("reset", {bus.stop, bus.busy, bus.out, bus.overflow, bus.cmp_lt, bus.cmp_eq, bus.cmp_gt, bus.err}, '0);
        rst_n = 1'b1;

        do_op(ADD, fs(0, 5), w(0, 100), w(0, 23), 0);
        expect_op("add", 7, w(0, 123), 1'b0, 3'b000, 1'b0);
        do_op(ADD, fs(0, 5), w(0, (1 << 30) - 1), w(0, 1), 3);
        expect_op("add_wrap", 7, w(0, 0), 1'b1, 3'b000, 1'b0);
        do_op(SUB, fs(0, 5), w(1, 50), w(1, 50), 0);
        expect_op("sub_negzero", 7, w(1, 0), 1'b0, 3'b000, 1'b0);
        do_op(ADD, fs(4, 5), w(0, 10), w(1, BYTES12345), 0);
        expect_op("add_field45", 7, w(0, 271), 1'b0, 3'b000, 1'b0);
        do_op(SUB, fs(0, 5), w(0, 5), w(0, 9), 0);
        expect_op("sub_neg", 7, w(1, 4), 1'b0, 3'b000, 1'b0);
        do_op(ADD, fs(0, 5), w(0, (1 << 30) - 1), w(0, 2), 0);
        expect_op("add_ovf", 7, w(0, 1), 1'b1, 3'b000, 1'b0);
        do_op(CMP, fs(0, 5), w(0, 0), w(1, 0), 0);
        expect_op("cmp_zeros", 2, w(0, 1), 1'b0, 3'b010, 1'b0);
        do_op(CMP, fs(0, 5), w(1, 3), w(0, 2), 0);
        expect_op("cmp_lt", 2, w(0, 1), 1'b0, 3'b100, 1'b0);
        do_op(CMP, fs(4, 5), w(0, 261), w(1, BYTES12345), 0);
        expect_op("cmp_field_eq", 2, w(0, 1), 1'b0, 3'b010, 1'b0);
        do_op(CMP, fs(0, 0), w(0, 5), w(1, 77), 0);
        expect_op("cmp_field00", 2, w(0, 1), 1'b0, 3'b001, 1'b0);
        do_op(ADD, fs(0, 5), w(0, (1 << 30) - 1), w(0, 2), 0);
        expect_op("add_ovf2", 7, w(0, 1), 1'b1, 3'b000, 1'b0);
        do_op(ADD, fs(3, 2), w(0, 1), w(0, 1), 1);
        expect_op("err_rl", 2, w(0, 1), 1'b1, 3'b000, 1'b1);
        do_op(CMP, fs(0, 5), w(0, 7), w(0, 2), 0);
        expect_op("cmp_gt", 2, w(0, 1), 1'b0, 3'b001, 1'b0);
        do_op(SUB, fs(0, 6), w(0, 1), w(0, 1), 1);
        expect_op("err_r6", 2, w(0, 1), 1'b0, 3'b000, 1'b1);
        do_op(BAD, fs(0, 5), w(0, 1), w(0, 1), 0);
        expect_op("err_op", 2, w(0, 1), 1'b0, 3'b000, 1'b1);

        @(negedge clk);
        bus.start = 1'b1; bus.op = ADD; bus.field = fs(0, 5); bus.in1 = w(0, 7); bus.in2 = w(0, 8);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_abort", {bus.stop, bus.busy, bus.out, bus.overflow, bus.cmp_lt, bus.cmp_eq, bus.cmp_gt, bus.err}, '0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.stop || bus.busy) seen = 1'b1;
        end
        check("rst_nostop", seen, 1'b0);
        rst_n = 1'b1;
        do_op(ADD, fs(0, 5), w(0, 7), w(0, 8), 0);
        expect_op("add_after_rst", 7, w(0, 15), 1'b0, 3'b000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/addsub_field.md
# addsub_field

Parametrised sign-magnitude add/subtract/compare unit for the MIX arithmetic path. It generalises word width (BYTES × BYTE_W magnitude plus one sign bit) and adds MIX field-spec (L:R) extraction of the memory operand. It also adds an ADD/SUB/CMP mode and a byte-serial datapath with a start/stop handshake. It sits between rA / memory operand fetch and the overflow toggle / comparison indicator.

## Interface
Parameters:
- BYTES, 5, bytes per word; magnitude width M = BYTES*BYTE_W, word width W = M+1
- BYTE_W, 6, bits per byte
- FW (derived), $clog2(BYTES+1), width of each field index

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when idle
- op  in  2  00 ADD, 01 SUB, 10 CMP, 11 reserved
- field  in  2*FW  {L,R}; byte 1 is the most significant byte, 0 selects the sign
- in1  in  W  register operand; bit W-1 is the sign (1 = negative)
- in2  in  W  memory word
- stop  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after start is accepted until the stop cycle inclusive
- out  out  W  arithmetic result
- overflow  out  1  magnitude carry-out for this operation
- cmp_lt / cmp_eq / cmp_gt  out  1 each  comparison result of in1 against V
- err  out  1  illegal field or op

## Operation
- Reset values: stop=0, busy=0, out=0, overflow=0, cmp_*=0, err=0, FSM in IDLE.
- Field extraction gives V. Bytes L..R of in2 (L'=max(L,1)) are right-justified into an M-bit magnitude, with upper bytes zero. V sign is in2 sign if L=0, otherwise positive. L=0, R=0 gives a magnitude of 0 with the in2 sign.
- Error checks:
  - An illegal field is R<L or R>BYTES.
  - op=11 is illegal.
  - On either: err=1, stop is pulsed, out/overflow are held, cmp_* are cleared.
- FSM:
  - IDLE: start=1 latches in1, in2, op and field, then goes to PREP.
  - PREP: extracts V and checks errors. SUB inverts the V sign.
    - CMP or error goes to DONE.
    - Otherwise the unit selects the effective operation and goes to RUN with byte counter 0. Same signs means add magnitudes. Different signs means subtract the smaller magnitude from the larger, using a full-width magnitude compare.
  - RUN: processes one byte per cycle, LSB byte first, with a registered carry/borrow. After BYTES cycles it goes to DONE.
  - DONE: drives stop=1 and registers the outputs, then returns to IDLE.
- Result sign:
  - Effective add: sign of in1.
  - Effective subtract: sign of the larger-magnitude operand.
  - Zero magnitude result: sign of in1. This produces -0 where applicable.
- Overflow: carry out of the magnitude MSB on effective add. out keeps the low M bits. overflow is always 0 for subtract and CMP.
- CMP:
  - Signed compare of in1 against V. +0 and -0 are equal.
  - Exactly one cmp_* flag is 1.
  - out and overflow are held, except that overflow is cleared.
  - cmp_* flags are cleared on ADD/SUB completion.
- Outputs change only in the DONE cycle (or on reset) and are held until the next completion.
- start is ignored while busy. No queueing.
- rst_n low at any time: immediately returns to IDLE and sets all outputs to their reset values. No stop pulse for the aborted operation.

## Timing
- start high in cycle 0 (sampled at the end of cycle 0). PREP is cycle 1.
- ADD/SUB: RUN occupies cycles 2..BYTES+1. stop=1 in cycle BYTES+2, which is cycle 7 for BYTES=5.
- CMP and error: stop=1 in cycle 2.
- out, overflow, cmp_* and err are valid when stop=1 and stay stable afterwards.
- busy is 1 in cycles 1..stop cycle, and 0 in the cycle after stop. A new start is accepted in the cycle stop is high: start sampled in that cycle puts PREP in the next cycle.
- Throughput is one ADD/SUB per BYTES+2 cycles. Issuing start in each stop cycle (the stop cycle acts as cycle 0) gives back-to-back operations every BYTES+2 cycles.

## Test plan
Defaults BYTES=5, BYTE_W=6.
- ADD, in1=+100, in2=+23, field (0:5) -> out=+123, overflow=0, err=0, stop only in cycle 7, busy 1 in cycles 1..7.
- ADD, in1=+(2^30-1), in2=+1, field (0:5) -> out=+0, overflow=1. Then SUB, in1=-50, in2=-50 -> out=-0 (sign 1, magnitude 0), overflow=0.
- ADD, in1=+10, in2=- with bytes 1,2,3,4,5, field (4:5) -> V=+261, out=+271. SUB, in1=+5, in2=+9, field (0:5) -> out=-4.
- CMP, in1=+0, in2=-0, field (0:5) -> cmp_eq=1, stop in cycle 2, out unchanged. CMP, in1=-3, in2=+2 -> cmp_lt=1.
- field (3:2), then field (0:6), then op=11 -> err=1, stop in cycle 2, out/overflow held. start pulses during busy are ignored.
- rst_n low in cycle 4 of an ADD -> all outputs 0 immediately, no stop. A start after release completes normally in BYTES+2 cycles.
